// File: rtl/i2c_write_master_if.sv
// Bus bundle for the single-transaction I2C write engine: upstream
// request handshake plus the two I2C pin signals.
//
// Handshake: the requester pulses start for one clk together with a
// stable data word; the engine accepts it only while busy is low, holds
// busy high for the whole transfer and drops it in the same cycle that
// done pulses for one clk. start seen while busy is high is discarded,
// never queued. ack_error is valid from the done pulse until the next
// accepted start.
interface i2c_write_master_if #(
  parameter int NBYTES = 3
);
  logic                  start;
  logic [8*NBYTES-1:0]   data;
  logic                  busy;
  logic                  done;
  logic                  ack_error;
  logic                  i2c_sclk;
  logic                  sda;
  logic                  i2c_sdat_in;

  // master: the write engine itself (it is the I2C bus master)
  modport master (
    input  start, data, i2c_sdat_in,
    output busy, done, ack_error, i2c_sclk, sda
  );

  // slave: the register sequencer plus whatever listens on the pins
  modport slave (
    output start, data, i2c_sdat_in,
    input  busy, done, ack_error, i2c_sclk, sda
  );
endinterface

// File: rtl/i2c_write_master.sv
// I2C write engine for the WM8731 control port: START, NBYTES bytes
// MSB-first with an ACK slot after each, then STOP. Every SCL slot is
// four equal quarter periods of CLK_DIV clk, so the SCL period never
// changes across byte boundaries. A NACK aborts the remaining bytes.
module i2c_write_master #(
  parameter int CLK_DIV = 125,
  parameter int NBYTES  = 3
) (
  input  logic               clk,
  input  logic               reset,
  i2c_write_master_if.master bus,
  output logic [2:0]         o_dbg_state
);

  localparam int         W         = 8 * NBYTES;
  localparam logic [9:0] CNT_MAX   = 10'(CLK_DIV - 1);
  localparam logic [7:0] LAST_BYTE = 8'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         r_state;
  logic [9:0]     r_cnt;
  logic [1:0]     r_q;
  logic [2:0]     r_bit;
  logic [7:0]     r_byte;
  logic [W-1:0]   r_shift;
  logic           r_ack_sample;
  logic           r_busy;
  logic           r_done;
  logic           r_ack_error;
  logic           r_sclk;
  logic           r_sda;
  logic           w_qtick;

  // Quarter-period strobe; the counter is held at 0 outside active states.
  assign w_qtick = (r_cnt == CNT_MAX);

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ack_error = r_ack_error;
  assign bus.i2c_sclk  = r_sclk;
  assign bus.sda       = r_sda;
  assign o_dbg_state   = r_state;

  // Quarter timer, protocol FSM and registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_q          <= '0;
      r_bit        <= '0;
      r_byte       <= '0;
      r_shift      <= '0;
      r_ack_sample <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ack_error  <= 1'b0;
      r_sclk       <= 1'b1;
      r_sda        <= 1'b1;
    end else begin
      r_done <= 1'b0;

      if (r_state == S_IDLE || r_state == S_DONE || w_qtick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 10'd1;
      end

      if (w_qtick) begin
        r_q <= r_q + 2'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_sclk <= 1'b1;
          r_sda  <= 1'b1;
          r_busy <= 1'b0;
          r_q    <= '0;
          if (bus.start) begin
            r_shift     <= bus.data;
            r_ack_error <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end

        S_START: begin
          if (w_qtick) begin
            if (r_q == 2'd0) begin
              r_sda <= 1'b0;
            end else begin
              // START only spans two quarters, so realign the quarter
              // index so every bit slot begins at q0.
              r_sclk  <= 1'b0;
              r_bit   <= 3'd7;
              r_byte  <= '0;
              r_q     <= '0;
              r_state <= S_BIT;
            end
          end
        end

        S_BIT: begin
          if (w_qtick) begin
            case (r_q)
              2'd0: begin
                r_sclk <= 1'b0;
                r_sda  <= r_shift[W-1];
              end
              2'd2: r_sclk <= 1'b1;
              2'd3: begin
                r_shift <= {r_shift[W-2:0], 1'b0};
                if (r_bit == 3'd0) begin
                  r_state <= S_ACK;
                end else begin
                  r_bit <= r_bit - 3'd1;
                end
              end
              default: ;
            endcase
          end
        end

        S_ACK: begin
          if (w_qtick) begin
            case (r_q)
              2'd0: begin
                r_sclk <= 1'b0;
                r_sda  <= 1'b1;
              end
              2'd2: begin
                r_sclk       <= 1'b1;
                r_ack_sample <= bus.i2c_sdat_in;
              end
              2'd3: begin
                if (r_ack_sample) begin
                  r_ack_error <= 1'b1;
                  r_state     <= S_STOP;
                end else if (r_byte == LAST_BYTE) begin
                  r_state <= S_STOP;
                end else begin
                  r_byte  <= r_byte + 8'd1;
                  r_bit   <= 3'd7;
                  r_state <= S_BIT;
                end
              end
              default: ;
            endcase
          end
        end

        S_STOP: begin
          if (w_qtick) begin
            case (r_q)
              2'd0: begin
                r_sclk <= 1'b0;
                r_sda  <= 1'b0;
              end
              2'd2: r_sclk <= 1'b1;
              2'd3: begin
                r_sda   <= 1'b1;
                r_state <= S_DONE;
              end
              default: ;
            endcase
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Single-transaction I2C write engine that drives the WM8731 control bus. It sits between the codec register sequencer (upstream) and the I2C pins, which the bus functional model in the testbench listens on.
- On one `start` pulse it sends START, three bytes MSB-first (device address+W, register-high, register-low/data), checks ACK after each byte, then sends STOP.
- It reports completion and any NACK.

Parameters:
- CLK_DIV, 125, clk cycles per SCL quarter-period; SCL period = 4*CLK_DIV (100 kHz at 50 MHz clk). Legal range 2..1023.
- NBYTES, 3, bytes per transaction; the data width is 8*NBYTES.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- data  input  8*NBYTES  transfer word; bit [8*NBYTES-1] is sent first; latched on the accepted start.
- busy  output  1  high from the accepted start until the cycle done pulses.
- done  output  1  one-cycle pulse at the end of every transaction, including aborted ones.
- ack_error  output  1  set when any ACK slot samples 1; cleared on the next accepted start.
- i2c_sclk  output  1  SCL, push-pull.
- sda  output  1  SDA drive: 0 = pull low, 1 = release (pad/pull-up yields 1).
- i2c_sdat_in  input  1  sampled bus SDA level.

Behaviour:
- Reset values: busy=0, done=0, ack_error=0, i2c_sclk=1, sda=1, state=IDLE, quarter counter=0. Reset mid-transfer aborts immediately, with no STOP and no done pulse.
- Tick generator:
  - Counter runs 0..CLK_DIV-1 only while not IDLE; `qtick` is asserted when it reaches CLK_DIV-1.
  - A 2-bit quarter index q advances on each qtick.
  - All state/pin updates below occur on qtick.
- IDLE:
  - sclk=1, sda=1, busy=0.
  - start=1: latch data into the shift register, clear ack_error, set busy, counter=0, go to START.
  - start while busy is ignored.
- START (2 quarters):
  - q0: sda=0 with sclk=1.
  - q1: sclk=0; go to BIT with bit count=7 and byte count=0.
- BIT (4 quarters per bit):
  - q0: sclk=0, sda=shift MSB.
  - q1: hold.
  - q2: sclk=1.
  - q3: hold sclk high, shift left.
  - After bit count 0, go to ACK.
  - SDA changes only while sclk=0.
- ACK (4 quarters):
  - q0: sclk=0, sda=1 (release).
  - q2: sclk=1, sample i2c_sdat_in.
  - q3: if sample=1, set ack_error and go to STOP (abort remaining bytes).
  - Otherwise, if byte count=NBYTES-1, go to STOP; else byte count+1, bit count=7, go to BIT.
- STOP (4 quarters):
  - q0: sclk=0, sda=0.
  - q1: hold.
  - q2: sclk=1.
  - q3: sda=1 (rising SDA while SCL high); go to DONE.
- DONE (1 clk):
  - done=1 for exactly one clk; busy=0 in the same cycle; go to IDLE.
  - A start in the cycle after done is accepted.
- SCL shape:
  - Every bit and ACK slot is exactly 4*CLK_DIV clk with 50% duty, so the period is constant across byte boundaries.
  - Full transaction: 9*NBYTES SCL rising edges in BIT/ACK plus 1 in STOP (28 for NBYTES=3).
- Latency: start to done = (2 + 4*9*NBYTES + 4)*CLK_DIV + 2 clk. With NBYTES=3 and CLK_DIV=125 this is 14252 clk.
- Clock stretching is not supported.
- ack_error holds its value until the next accepted start.

Test Plan:
1. CLK_DIV=125, data=24'h341E00, FM ACKs all bytes -> FM reports START, correct 24'h341E00, and END. ack_error=0, one done pulse, busy low in the same cycle. 28 SCL rising edges; measured frequency 100 kHz with a constant period.
2. FM withholds ACK on byte 1, data=24'h340C00 -> exactly 9 SCL pulses then STOP. ack_error=1 at done; bytes 2 and 3 are never driven.
3. FM ACKs bytes 1–2 and NACKs byte 3 -> 27 data/ACK pulses, STOP, ack_error=1. A following start with full ACK clears ack_error to 0.
4. start pulsed again 1000 clk into a transfer with different data -> ignored; the transfer completes with the original data and a single done.
5. reset asserted mid byte 2 -> next clk: i2c_sclk=1, sda=1, busy=0, no done. A subsequent start produces a clean transaction.
6. Back-to-back: start asserted in the cycle after done with data=24'h341200 -> accepted immediately; the second transaction is correct and reports separate START and END.
